game_io_controller: RTL and testbench
=====================================

Name: game_io_controller

Overview:
- Memory-mapped I/O controller between the processor's MMIO write/read strobes and the game hardware.
- Owns the renderer-visible registers: game_state, bird_y and score.
  - Processor writes land in shadow registers.
  - Shadows commit to the renderer at frame start, so a frame never shows a torn update.
- Runs the PS2 space-key acknowledge handshake and latches key events for the processor.
- Generates the RNG reset pulse.
- Keeps a frame counter for game timing.

Parameters:
- RNG_PULSE, 4: width in clock cycles of the rng_reset pulse.
- ACK_TIMEOUT, 1024: maximum cycles key_ack stays high waiting for key_state to return to 0.
- FRAME_CNT_W, 16: width of the frame counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_wr_en  in  1  write strobe; may be held several cycles (processor runs at quarter clock); acted on at rising edge only.
- cpu_wr_addr  in  2  0=game_state, 1=bird_y, 2=score, 3=ctrl.
- cpu_wr_data  in  32  write data.
- cpu_rd_en  in  1  read strobe; rising edge only.
- cpu_rd_addr  in  2  0=status, 1=shadow bird_y, 2=shadow score, 3=frame count.
- cpu_rd_data  out  32  registered read data.
- key_state  in  2  from PS2: 0=none, 1=press, 2=release, 3=ignored.
- key_ack  out  1  clears the PS2 key_state latch.
- frame_start  in  1  one-cycle pulse per VGA frame.
- game_state  out  2  committed value.
- bird_y  out  16  committed value.
- score  out  16  committed value.
- rng_reset  out  1  RNG reseed pulse.

Behaviour:
- Reset values: every output is 0; shadows 0, flags 0, frame counter 0; key FSM in K_IDLE.
- Strobe edge detect: a write/read fires in the cycle where cpu_*_en=1 and its registered previous value was 0. Exactly one action per strobe, however long it is held.
- Writes, taking effect the cycle after the edge:
  - Addr 0 loads shadow state from data[1:0].
  - Addr 1 loads shadow bird_y from data[15:0].
  - Addr 2 loads shadow score from data[15:0].
  - Addr 3 (ctrl): bit0=1 commits all shadows to the outputs immediately; bit1=1 starts the rng_reset pulse. Both bits may be set together.
- Commit:
  - On frame_start, or on ctrl bit0, all three outputs take the shadow values in the same cycle.
  - If a write edge coincides with frame_start, the new write data is included in that commit (the commit sees the next-shadow value).
- rng_reset:
  - High for exactly RNG_PULSE cycles, starting the cycle after the ctrl edge.
  - A retrigger while the pulse is active restarts the count.
- Frame counter: increments on frame_start and wraps modulo 2^FRAME_CNT_W.
- Reads:
  - cpu_rd_data is valid 1 cycle after the read edge and holds until the next read edge.
  - Status word = {29'b0, drop, release_pend, press_pend}.
  - Reading status clears all three flags in the same cycle the data is registered.
  - If a flag sets in the same cycle as the clearing read, the flag stays set and the read returns its old value.
  - Addr 3 read returns the zero-extended frame counter.
- Key FSM, K_IDLE:
  - key_ack=0.
  - key_state=1: set press_pend (if already set, set drop instead); go to K_ACK.
  - key_state=2: set release_pend (same drop rule); go to K_ACK.
  - key_state=0 or 3: stay.
- Key FSM, K_ACK:
  - key_ack=1 and a timeout counter runs.
  - key_state==0 returns the FSM to K_IDLE and drops key_ack the next cycle.
  - If the counter reaches ACK_TIMEOUT-1, set drop and go to K_IDLE.
  - No new event is sampled while in K_ACK.
- Reset mid-operation clears everything, including an in-flight rng pulse and a high key_ack.

Decomposition:
- Shared game package: MMIO address constants (ADDR_STATE, ADDR_BIRD, ADDR_SCORE, ADDR_CTRL), status bit indices, key_state encodings (KEY_NONE, KEY_PRESS, KEY_RELEASE), and key FSM state encoding.
- One sub-module, key_ack_handshake: the key FSM, timeout counter and event-flag outputs.
- Everything else stays in game_io_controller.

Test Plan:
- Write shadows, then frame_start:
  - Stimulus: write addr1=0x00F0 with strobe held 4 cycles; write addr2=7; pulse frame_start.
  - Required: bird_y stays 0 until the cycle after frame_start, then reads 0x00F0 with score=7; exactly one write occurs despite the held strobe.
- Write coinciding with frame_start:
  - Stimulus: write addr0=1 in the same cycle as frame_start.
  - Required: game_state=1 after that commit.
- Ctrl 0x3:
  - Stimulus: write ctrl=0x3 with shadows already loaded.
  - Required: outputs take the shadow values next cycle; rng_reset high exactly 4 cycles.
  - Retrigger at pulse cycle 2: rng_reset stays high for 4 cycles counted from the retrigger.
- Key press handshake:
  - Stimulus: key_state=1, held for 10 cycles, then 0.
  - Required: key_ack high through the hold, low 1 cycle after key_state=0; status read returns 0x1; the next status read returns 0x0.
- Drop and timeout:
  - Stimulus: two presses with no status read between them; separately, key_state held at 1 for 1100 cycles.
  - Required: status read returns 0x5 after the double press; in the held case key_ack falls at cycle 1024 and drop is set.
- Frame counter wrap and reset:
  - Stimulus: 65536 frame_start pulses; separately, reset asserted during K_ACK and during an rng pulse.
  - Required: addr3 read returns 0 after the wrap; key_ack and rng_reset are 0 the cycle after reset.

Source files
------------

// File: rtl/game_io_controller_pkg.sv
// Shared MMIO map, status bit positions, PS2 key encodings and key FSM states.
package game_io_controller_pkg;

    localparam logic [1:0] ADDR_STATE  = 2'd0;
    localparam logic [1:0] ADDR_BIRD   = 2'd1;
    localparam logic [1:0] ADDR_SCORE  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [1:0] RD_STATUS   = 2'd0;
    localparam logic [1:0] RD_BIRD     = 2'd1;
    localparam logic [1:0] RD_SCORE    = 2'd2;
    localparam logic [1:0] RD_FRAME    = 2'd3;

    localparam int STAT_PRESS   = 0;
    localparam int STAT_RELEASE = 1;
    localparam int STAT_DROP    = 2;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_RNG     = 1;

    localparam logic [1:0] KEY_NONE    = 2'd0;
    localparam logic [1:0] KEY_PRESS   = 2'd1;
    localparam logic [1:0] KEY_RELEASE = 2'd2;

    typedef enum logic {
        K_IDLE = 1'b0,
        K_ACK  = 1'b1
    } key_fsm_t;

endpackage

// File: rtl/game_io_controller_key_ack_handshake.sv
// PS2 key acknowledge FSM: latches press/release/drop events and holds key_ack until key_state clears.
// Latency: key_ack rises the cycle after an event is sampled; events are ignored while acknowledging.
// Backpressure: none; a second unread event of the same kind, or an ack timeout, is reported as drop.
module game_io_controller_key_ack_handshake
    import game_io_controller_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] key_state,
    input  logic       flag_clr,
    output logic       key_ack,
    output logic       press_pend,
    output logic       release_pend,
    output logic       drop
);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    key_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_set, release_set, drop_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= K_IDLE;
            cnt_q        <= '0;
            press_pend   <= 1'b0;
            release_pend <= 1'b0;
            drop         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // a flag set in the same cycle as the clearing read survives the clear
            press_pend   <= (press_pend   & ~flag_clr) | press_set;
            release_pend <= (release_pend & ~flag_clr) | release_set;
            drop         <= (drop         & ~flag_clr) | drop_set;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_set   = 1'b0;
        release_set = 1'b0;
        drop_set    = 1'b0;
        case (state_q)
            K_IDLE: begin
                cnt_d = '0;
                if (key_state == KEY_PRESS) begin
                    if (press_pend) drop_set = 1'b1;
                    else            press_set = 1'b1;
                    state_d = K_ACK;
                end else if (key_state == KEY_RELEASE) begin
                    if (release_pend) drop_set = 1'b1;
                    else              release_set = 1'b1;
                    state_d = K_ACK;
                end
            end
            K_ACK: begin
                if (key_state == KEY_NONE) begin
                    state_d = K_IDLE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    drop_set = 1'b1;
                    state_d  = K_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = K_IDLE;
        endcase
    end

    assign key_ack = (state_q == K_ACK);

endmodule

// File: rtl/game_io_controller.sv
// MMIO bridge to game hardware: shadowed renderer registers, key event flags, RNG reseed pulse, frame counter.
// Latency: writes and reads act 1 cycle after the strobe rising edge; shadows commit on frame_start or ctrl.
// Backpressure: none; one action per strobe edge regardless of how long the strobe is held.
module game_io_controller
    import game_io_controller_pkg::*;
#(
    parameter int RNG_PULSE   = 4,
    parameter int ACK_TIMEOUT = 1024,
    parameter int FRAME_CNT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_wr_en,
    input  logic [1:0]  cpu_wr_addr,
    input  logic [31:0] cpu_wr_data,
    input  logic        cpu_rd_en,
    input  logic [1:0]  cpu_rd_addr,
    output logic [31:0] cpu_rd_data,
    input  logic [1:0]  key_state,
    output logic        key_ack,
    input  logic        frame_start,
    output logic [1:0]  game_state,
    output logic [15:0] bird_y,
    output logic [15:0] score,
    output logic        rng_reset
);
    localparam int RNG_W = $clog2(RNG_PULSE + 1);

    logic                   wr_en_q, rd_en_q;
    logic                   wr_fire, rd_fire;
    logic [1:0]             sh_state_q, sh_state_d;
    logic [15:0]            sh_bird_q, sh_bird_d;
    logic [15:0]            sh_score_q, sh_score_d;
    logic                   ctrl_fire, commit, rng_start, status_clr;
    logic [RNG_W-1:0]       rng_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   press_pend, release_pend, drop;
    logic [31:0]            rd_mux;
    logic                   unused_wr_hi;

    assign wr_fire    = cpu_wr_en & ~wr_en_q;
    assign rd_fire    = cpu_rd_en & ~rd_en_q;
    assign ctrl_fire  = wr_fire && (cpu_wr_addr == ADDR_CTRL);
    assign commit     = frame_start | (ctrl_fire & cpu_wr_data[CTRL_COMMIT]);
    assign rng_start  = ctrl_fire & cpu_wr_data[CTRL_RNG];
    assign status_clr = rd_fire && (cpu_rd_addr == RD_STATUS);
    assign rng_reset  = (rng_cnt_q != '0);
    assign unused_wr_hi = ^cpu_wr_data[31:16];

    // Commit uses the next-shadow values so a write landing with frame_start is not lost.
    always_comb begin
        sh_state_d = sh_state_q;
        sh_bird_d  = sh_bird_q;
        sh_score_d = sh_score_q;
        if (wr_fire) begin
            case (cpu_wr_addr)
                ADDR_STATE: sh_state_d = cpu_wr_data[1:0];
                ADDR_BIRD:  sh_bird_d  = cpu_wr_data[15:0];
                ADDR_SCORE: sh_score_d = cpu_wr_data[15:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (cpu_rd_addr)
            RD_STATUS: begin
                rd_mux[STAT_PRESS]   = press_pend;
                rd_mux[STAT_RELEASE] = release_pend;
                rd_mux[STAT_DROP]    = drop;
            end
            RD_BIRD:  rd_mux[15:0] = sh_bird_q;
            RD_SCORE: rd_mux[15:0] = sh_score_q;
            default:  rd_mux[FRAME_CNT_W-1:0] = frame_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            sh_state_q  <= '0;
            sh_bird_q   <= '0;
            sh_score_q  <= '0;
            game_state  <= '0;
            bird_y      <= '0;
            score       <= '0;
            rng_cnt_q   <= '0;
            frame_cnt_q <= '0;
            cpu_rd_data <= '0;
        end else begin
            wr_en_q    <= cpu_wr_en;
            rd_en_q    <= cpu_rd_en;
            sh_state_q <= sh_state_d;
            sh_bird_q  <= sh_bird_d;
            sh_score_q <= sh_score_d;
            if (commit) begin
                game_state <= sh_state_d;
                bird_y     <= sh_bird_d;
                score      <= sh_score_d;
            end
            if (rng_start)          rng_cnt_q <= RNG_W'(RNG_PULSE);
            else if (rng_cnt_q != '0) rng_cnt_q <= rng_cnt_q - 1'b1;
            if (frame_start) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (rd_fire)     cpu_rd_data <= rd_mux;
        end
    end

    game_io_controller_key_ack_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_key_ack_handshake (
        .clock        (clock),
        .reset        (reset),
        .key_state    (key_state),
        .flag_clr     (status_clr),
        .key_ack      (key_ack),
        .press_pend   (press_pend),
        .release_pend (release_pend),
        .drop         (drop)
    );

endmodule

// File: tb/tb_game_io_controller.sv
// Bench for game_io_controller: directed scenarios plus randomized MMIO traffic against a shadow/commit model.
module tb_game_io_controller;
    localparam int RNG_PULSE   = 4;
    localparam int ACK_TIMEOUT = 1024;

    logic        clock;
    logic        reset;
    logic        cpu_wr_en;
    logic [1:0]  cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_rd_en;
    logic [1:0]  cpu_rd_addr;
    logic [31:0] cpu_rd_data;
    logic [1:0]  key_state;
    logic        key_ack;
    logic        frame_start;
    logic [1:0]  game_state;
    logic [15:0] bird_y;
    logic [15:0] score;
    logic        rng_reset;

    int checks   = 0;
    int failures = 0;

    game_io_controller #(
        .RNG_PULSE   (RNG_PULSE),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .FRAME_CNT_W (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_rd_addr (cpu_rd_addr),
        .cpu_rd_data (cpu_rd_data),
        .key_state   (key_state),
        .key_ack     (key_ack),
        .frame_start (frame_start),
        .game_state  (game_state),
        .bird_y      (bird_y),
        .score       (score),
        .rng_reset   (rng_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset       = 1'b1;
        cpu_wr_en   = 1'b0;
        cpu_rd_en   = 1'b0;
        cpu_wr_addr = 2'd0;
        cpu_rd_addr = 2'd0;
        cpu_wr_data = 32'd0;
        key_state   = 2'd0;
        frame_start = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic mmio_write(input logic [1:0] a, input logic [31:0] d);
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        tick;
        cpu_wr_en = 1'b0;
        tick;
    endtask

    task automatic mmio_read(input logic [1:0] a, output logic [31:0] d);
        cpu_rd_en   = 1'b1;
        cpu_rd_addr = a;
        tick;
        d = cpu_rd_data;
        cpu_rd_en = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        do_reset;
        checks++;
        if ({game_state, bird_y, score, key_ack, rng_reset, cpu_rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got state=%h bird=%h score=%h ack=%b rng=%b rd=%h required all zero",
                     game_state, bird_y, score, key_ack, rng_reset, cpu_rd_data);
        end
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL reset_status got=%h required=0", rd); end
        mmio_read(2'd3, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("FAIL reset_frame got=%h required=0", rd); end
    endtask

    task automatic test_shadow_commit;
        logic [31:0] rd;
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 2'd1;
        cpu_wr_data = 32'h0000_00F0;
        tick;
        cpu_wr_data = 32'h0000_DEAD;
        repeat (3) tick;
        cpu_wr_en = 1'b0;
        tick;
        mmio_write(2'd2, 32'd7);
        mmio_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0000_00F0) begin failures++; $display("FAIL held_strobe_once got=%h required=000000f0", rd); end
        frame_start = 1'b1;
        checks++;
        if (bird_y !== 16'd0 || score !== 16'd0) begin
            failures++;
            $display("FAIL precommit_outputs got bird=%h score=%h required 0 0", bird_y, score);
        end
        tick;
        frame_start = 1'b0;
        checks++;
        if (bird_y !== 16'h00F0 || score !== 16'd7) begin
            failures++;
            $display("FAIL frame_commit got bird=%h score=%h required 00f0 0007", bird_y, score);
        end
    endtask

    task automatic test_write_with_frame;
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 2'd0;
        cpu_wr_data = 32'd1;
        frame_start = 1'b1;
        tick;
        cpu_wr_en   = 1'b0;
        frame_start = 1'b0;
        checks++;
        if (game_state !== 2'd1) begin failures++; $display("FAIL write_with_frame got=%h required=1", game_state); end
        tick;
    endtask

    task automatic test_ctrl;
        logic exp_rng;
        mmio_write(2'd0, 32'd2);
        mmio_write(2'd1, 32'h1234);
        mmio_write(2'd2, 32'h55);
        checks++;
        if (bird_y !== 16'h00F0) begin failures++; $display("FAIL shadow_not_live got=%h required=00f0", bird_y); end
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 2'd3;
        cpu_wr_data = 32'h3;
        for (int c = 1; c <= 6; c++) begin
            tick;
            cpu_wr_en = 1'b0;
            exp_rng = (c <= RNG_PULSE);
            checks++;
            if (rng_reset !== exp_rng) begin
                failures++;
                $display("FAIL ctrl_rng_cycle%0d got=%b required=%b", c, rng_reset, exp_rng);
            end
            if (c == 1) begin
                checks++;
                if (game_state !== 2'd2 || bird_y !== 16'h1234 || score !== 16'h55) begin
                    failures++;
                    $display("FAIL ctrl_commit got state=%h bird=%h score=%h required 2 1234 0055",
                             game_state, bird_y, score);
                end
            end
        end
    endtask

    task automatic test_rng_retrigger;
        logic exp_rng;
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 2'd3;
        cpu_wr_data = 32'h2;
        tick;
        cpu_wr_en = 1'b0;
        tick;
        cpu_wr_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            cpu_wr_en = 1'b0;
            exp_rng = (c <= RNG_PULSE);
            checks++;
            if (rng_reset !== exp_rng) begin
                failures++;
                $display("FAIL retrigger_cycle%0d got=%b required=%b", c, rng_reset, exp_rng);
            end
        end
    endtask

    task automatic test_key_press;
        logic [31:0] rd;
        int          low_seen;
        low_seen  = 0;
        key_state = 2'd1;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (key_ack !== 1'b1) low_seen++;
        end
        checks++;
        if (low_seen != 0) begin failures++; $display("FAIL ack_during_hold low_cycles=%0d required=0", low_seen); end
        key_state = 2'd0;
        tick;
        checks++;
        if (key_ack !== 1'b0) begin failures++; $display("FAIL ack_release got=%b required=0", key_ack); end
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'h1) begin failures++; $display("FAIL press_status got=%h required=1", rd); end
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL status_cleared got=%h required=0", rd); end
    endtask

    task automatic test_drop_release;
        logic [31:0] rd;
        repeat (2) begin
            key_state = 2'd1;
            tick;
            key_state = 2'd0;
            tick;
        end
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'h5) begin failures++; $display("FAIL double_press got=%h required=5", rd); end
        key_state = 2'd2;
        tick;
        key_state = 2'd0;
        tick;
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL release_status got=%h required=2", rd); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        int          first_low;
        first_low = -1;
        key_state = 2'd1;
        tick;
        for (int k = 1; k <= 1100; k++) begin
            if (key_ack !== 1'b1 && first_low < 0) first_low = k;
            tick;
        end
        checks++;
        if (first_low != ACK_TIMEOUT + 1) begin
            failures++;
            $display("FAIL ack_timeout high_cycles=%0d required=%0d", first_low - 1, ACK_TIMEOUT);
        end
        key_state = 2'd0;
        tick;
        tick;
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'h5) begin failures++; $display("FAIL timeout_drop got=%h required=5", rd); end
    endtask

    task automatic test_random;
        logic [1:0]  s_state, e_state, waddr, raddr;
        logic [15:0] s_bird, e_bird, s_score, e_score, fcnt;
        logic [31:0] wdata, exp_rd;
        int          rem, op;
        logic        fs;
        do_reset;
        s_state = 0; s_bird = 0; s_score = 0;
        e_state = 0; e_bird = 0; e_score = 0;
        fcnt = 0; rem = 0; exp_rd = 0;
        for (int i = 0; i < 200; i++) begin
            op    = $urandom_range(0, 2);
            waddr = 2'($urandom_range(0, 3));
            raddr = 2'($urandom_range(0, 3));
            wdata = $urandom;
            fs    = (op == 2) || (op == 0 && $urandom_range(0, 3) == 0);
            for (int c = 0; c < 2; c++) begin
                cpu_wr_en   = (c == 0 && op == 0);
                cpu_rd_en   = (c == 0 && op == 1);
                cpu_wr_addr = waddr;
                cpu_wr_data = wdata;
                cpu_rd_addr = raddr;
                frame_start = (c == 0) && fs;
                tick;
                if (c == 0 && op == 1)
                    exp_rd = (raddr == 2'd1) ? {16'd0, s_bird} :
                             (raddr == 2'd2) ? {16'd0, s_score} :
                             (raddr == 2'd3) ? {16'd0, fcnt} : 32'd0;
                if (c == 0 && op == 0) begin
                    if (waddr == 2'd0) s_state = wdata[1:0];
                    if (waddr == 2'd1) s_bird  = wdata[15:0];
                    if (waddr == 2'd2) s_score = wdata[15:0];
                end
                if (frame_start || (c == 0 && op == 0 && waddr == 2'd3 && wdata[0])) begin
                    e_state = s_state; e_bird = s_bird; e_score = s_score;
                end
                if (c == 0 && op == 0 && waddr == 2'd3 && wdata[1]) rem = RNG_PULSE;
                else if (rem > 0) rem--;
                if (frame_start) fcnt++;
                checks++;
                if (game_state !== e_state || bird_y !== e_bird || score !== e_score ||
                    rng_reset !== (rem > 0) || cpu_rd_data !== exp_rd) begin
                    failures++;
                    $display("FAIL rand_%0d_%0d got st=%h by=%h sc=%h rng=%b rd=%h required st=%h by=%h sc=%h rng=%b rd=%h",
                             i, c, game_state, bird_y, score, rng_reset, cpu_rd_data,
                             e_state, e_bird, e_score, rem > 0, exp_rd);
                end
            end
        end
        frame_start = 1'b0;
    endtask

    task automatic test_frame_wrap;
        logic [31:0] rd, base;
        logic [15:0] exp16;
        mmio_read(2'd3, base);
        frame_start = 1'b1;
        repeat (65535) tick;
        frame_start = 1'b0;
        mmio_read(2'd3, rd);
        exp16 = base[15:0] + 16'hFFFF;
        checks++;
        if (rd !== {16'd0, exp16}) begin failures++; $display("FAIL frame_pre_wrap got=%h required=%h", rd, exp16); end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        mmio_read(2'd3, rd);
        checks++;
        if (rd !== base) begin failures++; $display("FAIL frame_wrap got=%h required=%h", rd, base); end
    endtask

    task automatic test_reset_midop;
        logic [31:0] rd;
        key_state   = 2'd1;
        tick;
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = 2'd3;
        cpu_wr_data = 32'h2;
        tick;
        cpu_wr_en = 1'b0;
        checks++;
        if (key_ack !== 1'b1 || rng_reset !== 1'b1) begin
            failures++;
            $display("FAIL midop_setup got ack=%b rng=%b required 1 1", key_ack, rng_reset);
        end
        reset = 1'b1;
        tick;
        checks++;
        if (key_ack !== 1'b0 || rng_reset !== 1'b0 || bird_y !== 16'd0) begin
            failures++;
            $display("FAIL midop_reset got ack=%b rng=%b bird=%h required 0 0 0", key_ack, rng_reset, bird_y);
        end
        key_state = 2'd0;
        reset     = 1'b0;
        tick;
        mmio_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL midop_status got=%h required=0", rd); end
    endtask

    initial begin
        test_reset;
        test_shadow_commit;
        test_write_with_frame;
        test_ctrl;
        test_rng_retrigger;
        test_key_press;
        test_drop_release;
        test_timeout;
        test_random;
        test_frame_wrap;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
